// File: rtl/vote_tally.sv
// vote_tally: clocked voting session controller.
// Runs one session at a time: collects one ballot per voter (first ballot wins)
// plus a chair ballot within a bounded window, then publishes a registered
// pass/fail verdict with a one-cycle done pulse.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous active-high reset
//   start      - opens a session (sampled only in IDLE)
//   cast[N]    - per-voter ballot strobes
//   yes[N]     - per-voter ballot values, qualified by cast
//   chair_cast - chair ballot strobe
//   chair_yes  - chair ballot value, qualified by chair_cast
//   busy       - high while the session is open
//   done       - one-cycle verdict pulse
//   pass       - verdict, held until the next accepted start
//   yes_cnt    - accepted yes ballots from ordinary voters
//   voted      - mask of voters whose ballot was accepted
module vote_tally #(
    parameter int N       = 4,
    parameter int THRESH  = 2,
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  cast,
    input  logic [N-1:0]  yes,
    input  logic          chair_cast,
    input  logic          chair_yes,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] yes_cnt,
    output logic [N-1:0]  voted
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OPEN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          chair_voted, chair_voted_n;
    logic          chair_yes_l, chair_yes_l_n;
    logic          pass_n;
    logic [CW-1:0] yes_cnt_n;
    logic [N-1:0]  voted_n;
    logic [N-1:0]  accept;
    logic [CW-1:0] yes_inc;

    // Only voters that have not yet voted are accepted; first ballot wins.
    assign accept = cast & ~voted;

    always_comb begin
        yes_inc = '0;
        for (int i = 0; i < N; i++) begin
            yes_inc = yes_inc + CW'(accept[i] & yes[i]);
        end
    end

    always_comb begin
        state_n       = state;
        timer_n       = timer;
        chair_voted_n = chair_voted;
        chair_yes_l_n = chair_yes_l;
        pass_n        = pass;
        yes_cnt_n     = yes_cnt;
        voted_n       = voted;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n       = S_OPEN;
                    timer_n       = '0;
                    chair_voted_n = 1'b0;
                    chair_yes_l_n = 1'b0;
                    pass_n        = 1'b0;
                    yes_cnt_n     = '0;
                    voted_n       = '0;
                end
            end
            S_OPEN: begin
                voted_n   = voted | cast;
                yes_cnt_n = yes_cnt + yes_inc;
                if (chair_cast && !chair_voted) begin
                    chair_voted_n = 1'b1;
                    chair_yes_l_n = chair_yes;
                end
                timer_n = timer + TW'(1);
                // Ballots on the final timer edge still count toward the verdict.
                if (((&voted_n) && chair_voted_n) || (timer == TIMER_LAST)) begin
                    state_n = S_DONE;
                    // Absent chair vetoes; absent voters count as no.
                    pass_n  = chair_voted_n & chair_yes_l_n & (yes_cnt_n >= CW'(THRESH));
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            chair_voted <= 1'b0;
            chair_yes_l <= 1'b0;
            pass        <= 1'b0;
            yes_cnt     <= '0;
            voted       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            chair_voted <= chair_voted_n;
            chair_yes_l <= chair_yes_l_n;
            pass        <= pass_n;
            yes_cnt     <= yes_cnt_n;
            voted       <= voted_n;
            busy        <= (state_n == S_OPEN);
            done        <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: directed self-checking bench for vote_tally (N=4, THRESH=2,
// TIMEOUT=16). Inputs change 1 time unit after each rising edge; outputs are
// sampled at the same point.
module tb_vote_tally;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] cast;
    logic [3:0] yes;
    logic       chair_cast;
    logic       chair_yes;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] yes_cnt;
    logic [3:0] voted;

    int checks   = 0;
    int failures = 0;

    vote_tally #(
        .N      (4),
        .THRESH (2),
        .TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cast      (cast),
        .yes       (yes),
        .chair_cast(chair_cast),
        .chair_yes (chair_yes),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .yes_cnt   (yes_cnt),
        .voted     (voted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one set of ballots for exactly one edge.
    task automatic ballot(input logic [3:0] c, input logic [3:0] y, input logic cc,
                          input logic cy);
        cast       = c;
        yes        = y;
        chair_cast = cc;
        chair_yes  = cy;
        tick();
        cast       = '0;
        yes        = '0;
        chair_cast = 1'b0;
        chair_yes  = 1'b0;
    endtask

    task automatic open_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int busy_cycles;
        int done_seen;

        reset      = 1'b1;
        start      = 1'b0;
        cast       = '0;
        yes        = '0;
        chair_cast = 1'b0;
        chair_yes  = 1'b0;
        #1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_cnt", 32'(yes_cnt), 0);
        check("rst_voted", 32'(voted), 0);
        reset = 1'b0;

        // Normal pass: ballots on separate cycles.
        open_session();
        check("np_busy", 32'(busy), 1);
        check("np_cnt0", 32'(yes_cnt), 0);
        ballot(4'b0000, 4'b0000, 1'b1, 1'b1);
        ballot(4'b0001, 4'b0001, 1'b0, 1'b0);
        ballot(4'b0010, 4'b0010, 1'b0, 1'b0);
        check("np_cnt_mid", 32'(yes_cnt), 2);
        ballot(4'b0100, 4'b0000, 1'b0, 1'b0);
        check("np_not_done", 32'(done), 0);
        ballot(4'b1000, 4'b0000, 1'b0, 1'b0);
        check("np_done", 32'(done), 1);
        check("np_busy_off", 32'(busy), 0);
        check("np_pass", 32'(pass), 1);
        check("np_cnt", 32'(yes_cnt), 2);
        check("np_voted", 32'(voted), 4'hF);
        tick();
        check("np_done_drop", 32'(done), 0);
        check("np_pass_hold", 32'(pass), 1);

        // Chair veto.
        open_session();
        check("cv_pass_clr", 32'(pass), 0);
        ballot(4'b1111, 4'b1111, 1'b1, 1'b0);
        check("cv_done", 32'(done), 1);
        check("cv_pass", 32'(pass), 0);
        check("cv_cnt", 32'(yes_cnt), 4);
        tick();

        // Simultaneous ballots: busy for one cycle.
        open_session();
        check("sim_busy", 32'(busy), 1);
        ballot(4'b1111, 4'b0111, 1'b1, 1'b1);
        check("sim_done", 32'(done), 1);
        check("sim_busy_off", 32'(busy), 0);
        check("sim_cnt", 32'(yes_cnt), 3);
        check("sim_pass", 32'(pass), 1);
        tick();

        // Duplicate ballot: second v0 ballot ignored.
        open_session();
        ballot(4'b0001, 4'b0001, 1'b0, 1'b0);
        ballot(4'b0001, 4'b0000, 1'b0, 1'b0);
        check("dup_cnt_mid", 32'(yes_cnt), 1);
        check("dup_voted_mid", 32'(voted), 4'b0001);
        ballot(4'b1110, 4'b0000, 1'b1, 1'b1);
        check("dup_done", 32'(done), 1);
        check("dup_cnt", 32'(yes_cnt), 1);
        check("dup_pass", 32'(pass), 0);
        tick();

        // Timeout, with a stray start during OPEN.
        open_session();
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        ballot(4'b0001, 4'b0001, 1'b1, 1'b1);
        cyc = 2;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cycles++;
            if (cyc == 8) start = 1'b1;
            tick();
            start = 1'b0;
            cyc++;
        end
        check("to_done_seen", 32'(done), 1);
        check("to_latency", 32'(cyc), 17);
        check("to_busy_cycles", 32'(busy_cycles), 16);
        check("to_pass", 32'(pass), 0);
        check("to_cnt", 32'(yes_cnt), 1);
        check("to_voted", 32'(voted), 4'b0001);
        tick();
        check("to_idle_done", 32'(done), 0);
        check("to_idle_busy", 32'(busy), 0);

        // Reset mid-OPEN.
        open_session();
        ballot(4'b0001, 4'b0001, 1'b0, 1'b0);
        ballot(4'b0010, 4'b0010, 1'b0, 1'b0);
        check("rm_cnt_pre", 32'(yes_cnt), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_busy", 32'(busy), 0);
        check("rm_done", 32'(done), 0);
        check("rm_pass", 32'(pass), 0);
        check("rm_cnt", 32'(yes_cnt), 0);
        check("rm_voted", 32'(voted), 0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        check("rm_no_done", 32'(done_seen), 0);
        ballot(4'b1111, 4'b1111, 1'b1, 1'b1);
        check("idle_cast_voted", 32'(voted), 0);
        check("idle_cast_cnt", 32'(yes_cnt), 0);
        check("idle_cast_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vote_tally.md
# vote_tally

Parametrised, clocked successor to the combinational chair-plus-majority voter. It runs one voting session at a time: it collects one ballot per voter over a bounded window, counts the yes votes and applies a chair veto, then publishes a registered pass/fail verdict. It sits between the per-voter button/strobe logic and the result display.

## Interface

- `N`, default 4: number of ordinary voters. Legal range 1..16.
- `THRESH`, default 2: minimum yes count among ordinary voters needed to pass. Legal range 1..N.
- `TIMEOUT`, default 16: maximum number of cycles spent in OPEN before the session is force-closed. Must be ≥1.
- `CW`, derived as $clog2(N+1): width of the yes counter.

Ports:

- `clk` in 1: sole clock; all logic updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: opens a session. Sampled only in IDLE.
- `cast` in N: per-voter ballot strobe, one cycle wide per ballot.
- `yes` in N: per-voter ballot value (1 = yes). Qualified by `cast[i]`.
- `chair_cast` in 1: chair ballot strobe.
- `chair_yes` in 1: chair ballot value. Qualified by `chair_cast`.
- `busy` out 1: high while in OPEN.
- `done` out 1: one-cycle pulse marking the final verdict.
- `pass` out 1: verdict. Valid from the `done` cycle and held until the next accepted `start`.
- `yes_cnt` out CW: number of accepted yes ballots from ordinary voters.
- `voted` out N: mask of voters whose ballot has been accepted.

## Operation

- FSM states: IDLE, OPEN, DONE. Encoding is free. All outputs are registered.
- **IDLE:** `start`=1 → OPEN. On the same edge, clear `voted`, `yes_cnt`, the chair-voted and chair-yes flags, `pass` and the timer. `cast`/`chair_cast` are ignored in IDLE.
- **OPEN, voter ballots:** on each edge, for every i with `cast[i]`=1 and `voted[i]`=0:
  - set `voted[i]`;
  - add `yes[i]` to `yes_cnt`.
  - Any number of voters may be accepted on the same edge; the increment is the popcount of the accepted yes bits.
  - `cast[i]` with `voted[i]`=1 is ignored, so the first ballot wins.
- **OPEN, chair ballot:** same rule. The first `chair_cast` latches `chair_yes`; later ones are ignored.
- **Completion:** if, after this edge's updates, all N voters and the chair have voted → DONE.
- **Timeout:** the timer counts edges spent in OPEN, starting at 0 on entry. If the timer is TIMEOUT-1 on an edge and the session is not complete → DONE. Ballots presented on that edge are still accepted.
- **Entering DONE:** `pass` is set to chair_voted & chair_yes_latched & (`yes_cnt_next` ≥ THRESH).
  - An absent chair counts as a veto.
  - An absent voter counts as no.
- **DONE:** lasts exactly one cycle with `done`=1, then → IDLE. `start` asserted during OPEN or DONE is ignored.
- `yes_cnt` and `voted` hold their final values in IDLE until the next accepted `start`.
- **Widths:** `yes_cnt` can never exceed N, so it cannot overflow CW bits. The timer is $clog2(TIMEOUT) bits wide, minimum 1.

## Timing

- **Reset:** on any edge with `reset`=1 the next state is IDLE and `busy`, `done`, `pass`, `yes_cnt`, `voted`, the chair flags and the timer are all 0. Reset overrides every other input.
- **Reset mid-OPEN:** aborts the session. No `done` pulse is produced and the partial counts are discarded.
- **Start latency:** `start` sampled high in IDLE at edge t → `busy`=1 and cleared counters visible in cycle t+1.
- **Ballot latency:** a ballot sampled at edge k shows in `voted`/`yes_cnt` in cycle k+1.
- **Completion latency:** if edge k completes the session, then in cycle k+1:
  - `busy`=0, `done`=1;
  - `pass` is valid;
  - `yes_cnt`/`voted` show their final values.
  - In cycle k+2, `done`=0 and the FSM is back in IDLE.
- **Timeout latency:** with no completion, `done` is asserted in cycle t+1+TIMEOUT for a `start` at edge t. `busy` is high for exactly TIMEOUT cycles.
- **Back-to-back sessions:** minimum spacing from `start` to the next accepted `start` is 3 edges (IDLE→OPEN, OPEN→DONE, DONE→IDLE).

## Test plan

All scenarios use N=4, THRESH=2, TIMEOUT=16.

- **Normal pass:** start; then on separate cycles chair yes, v0 yes, v1 yes, v2 no, v3 no → `done` one cycle after the v3 edge, `pass`=1, `yes_cnt`=2, `voted`=4'b1111.
- **Chair veto:** chair casts no and all four voters cast yes → `pass`=0, `yes_cnt`=4.
- **Simultaneous ballots:** a single cycle with `cast`=4'b1111, `yes`=4'b0111, chair yes → `yes_cnt`=3 and `done`=1 in the very next cycle, `pass`=1, `busy` high for exactly 1 cycle.
- **Duplicate ballot:** v0 casts yes, then v0 casts no, then the rest cast no with chair yes → `yes_cnt`=1 and `pass`=0; the second v0 ballot is ignored.
- **Timeout:** chair yes and v0 yes, then no further casts → `done` in the 17th cycle after the `start` edge, `pass`=0, `yes_cnt`=1, `voted`=4'b0001. A `start` pulse during OPEN has no effect.
- **Reset mid-OPEN:**
  - Reset asserted after 2 ballots → next cycle has all outputs 0 and no `done` pulse.
  - Casts presented in IDLE afterwards leave `voted`=0.
